// File: rtl/voice_allocator_if.sv
// Voice allocator bus: scan enable and key levels in, voice state and events out.
interface voice_allocator_if #(
   parameter int unsigned NUM_KEYS   = 36,
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned KEY_W      = 6
);
   logic                        en;
   logic [NUM_KEYS-1:0]         keys;
   logic [NUM_VOICES-1:0]       voice_active;
   logic [NUM_VOICES*KEY_W-1:0] voice_note;
   logic                        event_valid;
   logic                        event_on;
   logic                        event_steal;
   logic [2:0]                  event_voice;
   logic [KEY_W-1:0]            event_note;
   logic                        scan_done;

   modport master (
      output en, keys,
      input  voice_active, voice_note, event_valid, event_on, event_steal,
             event_voice, event_note, scan_done
   );

   modport slave (
      input  en, keys,
      output voice_active, voice_note, event_valid, event_on, event_steal,
             event_voice, event_note, scan_done
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans one key per cycle, assigns pressed keys to free
// voice slots and frees slots on release. Optional macro VOICE_STEAL_EN lets a
// new key steal the oldest voice when the pool is full.
module voice_allocator #(
   parameter int unsigned NUM_KEYS   = 36,
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned KEY_W      = 6
) (
   input logic              clk,
   input logic              rst,
   voice_allocator_if.slave bus
);
   localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);
   localparam logic [2:0]       AGE_MAX  = 3'(NUM_VOICES - 1);

   logic [KEY_W-1:0]      scan_idx_q, scan_idx_d;
   logic [NUM_VOICES-1:0] active_q, active_d;
   logic [KEY_W-1:0]      note_q [NUM_VOICES];
   logic [KEY_W-1:0]      note_d [NUM_VOICES];
   logic [2:0]            age_q  [NUM_VOICES];
   logic [2:0]            age_d  [NUM_VOICES];
   logic                  ev_valid_q, ev_valid_d;
   logic                  ev_on_q, ev_on_d;
   logic                  ev_steal_q, ev_steal_d;
   logic [2:0]            ev_voice_q, ev_voice_d;
   logic [KEY_W-1:0]      ev_note_q, ev_note_d;
   logic                  scan_done_q, scan_done_d;

   logic                  key_now;
   logic                  hit;
   logic [2:0]            hit_v;
   logic                  free_found;
   logic [2:0]            free_v;
   logic                  assign_en;
   logic [2:0]            tgt;
`ifdef VOICE_STEAL_EN
   logic [2:0]            steal_v;
   logic [2:0]            oldest;
`endif

   assign key_now = bus.keys[scan_idx_q];

   // Match the scanned key against the voices and find the lowest free slot.
   always_comb begin
      hit        = 1'b0;
      hit_v      = '0;
      free_found = 1'b0;
      free_v     = '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         if (active_q[v] && (note_q[v] == scan_idx_q)) begin
            hit   = 1'b1;
            hit_v = 3'(v);
         end
         if (!active_q[v] && !free_found) begin
            free_found = 1'b1;
            free_v     = 3'(v);
         end
      end
   end

`ifdef VOICE_STEAL_EN
   // Oldest voice; strict compare keeps the lowest index on ties.
   always_comb begin
      steal_v = '0;
      oldest  = age_q[0];
      for (int unsigned v = 1; v < NUM_VOICES; v++) begin
         if (age_q[v] > oldest) begin
            oldest  = age_q[v];
            steal_v = 3'(v);
         end
      end
   end
`endif

   // Next-state: scan advance, release/assign decision, age update, event.
   always_comb begin
      scan_idx_d  = scan_idx_q;
      active_d    = active_q;
      note_d      = note_q;
      age_d       = age_q;
      ev_valid_d  = 1'b0;
      ev_on_d     = 1'b0;
      ev_steal_d  = 1'b0;
      ev_voice_d  = '0;
      ev_note_d   = '0;
      scan_done_d = 1'b0;
      assign_en   = 1'b0;
      tgt         = '0;
      if (bus.en) begin
         scan_idx_d  = (scan_idx_q == LAST_KEY) ? '0 : scan_idx_q + 1'b1;
         scan_done_d = (scan_idx_q == LAST_KEY);
         if (hit && !key_now) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
               if (3'(v) == hit_v) active_d[v] = 1'b0;
            end
            ev_valid_d = 1'b1;
            ev_voice_d = hit_v;
            ev_note_d  = scan_idx_q;
         end else if (!hit && key_now) begin
            if (free_found) begin
               assign_en = 1'b1;
               tgt       = free_v;
            end
`ifdef VOICE_STEAL_EN
            else begin
               assign_en  = 1'b1;
               tgt        = steal_v;
               ev_steal_d = 1'b1;
            end
`endif
            if (assign_en) begin
               for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                  if (3'(v) == tgt) begin
                     active_d[v] = 1'b1;
                     note_d[v]   = scan_idx_q;
                     age_d[v]    = '0;
                  end else if (active_q[v] && (age_q[v] < AGE_MAX)) begin
                     age_d[v] = age_q[v] + 3'd1;
                  end
               end
               ev_valid_d = 1'b1;
               ev_on_d    = 1'b1;
               ev_voice_d = tgt;
               ev_note_d  = scan_idx_q;
            end
         end
      end
   end

   // State and output registers; reset clears voices without note-off events.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_idx_q  <= '0;
         active_q    <= '0;
         note_q      <= '{default: '0};
         age_q       <= '{default: '0};
         ev_valid_q  <= 1'b0;
         ev_on_q     <= 1'b0;
         ev_steal_q  <= 1'b0;
         ev_voice_q  <= '0;
         ev_note_q   <= '0;
         scan_done_q <= 1'b0;
      end else begin
         scan_idx_q  <= scan_idx_d;
         active_q    <= active_d;
         note_q      <= note_d;
         age_q       <= age_d;
         ev_valid_q  <= ev_valid_d;
         ev_on_q     <= ev_on_d;
         ev_steal_q  <= ev_steal_d;
         ev_voice_q  <= ev_voice_d;
         ev_note_q   <= ev_note_d;
         scan_done_q <= scan_done_d;
      end
   end

   // Pack per-voice note indices onto the flat output bus.
   always_comb begin
      bus.voice_note = '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         bus.voice_note[v*KEY_W +: KEY_W] = note_q[v];
      end
   end

   assign bus.voice_active = active_q;
   assign bus.event_valid  = ev_valid_q;
   assign bus.event_on     = ev_on_q;
   assign bus.event_steal  = ev_steal_q;
   assign bus.event_voice  = ev_voice_q;
   assign bus.event_note   = ev_note_q;
   assign bus.scan_done    = scan_done_q;
endmodule
